// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, reset PC, fetch step, NOP encoding
// and the IF/ID pipeline record consumed by decode.
package core_pkg;

    localparam int unsigned XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } if_id_t;

    typedef enum logic [1:0] {
        IFID_HOLD,
        IFID_LOAD,
        IFID_FLUSH
    } ifid_op_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load / hold / flush control; flush keeps the
// stored PC and replaces the instruction with a NOP.
module if_id_reg
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  ifid_op_e        op_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    output if_id_t          ifid_o
);

    if_id_t ifid_q, ifid_d;

    always_comb begin
        ifid_d = ifid_q;
        case (op_i)
            IFID_LOAD: begin
                ifid_d.valid = 1'b1;
                ifid_d.pc    = pc_i;
                ifid_d.instr = instr_i;
            end
            IFID_FLUSH: begin
                ifid_d.valid = 1'b0;
                ifid_d.instr = NOP_INSTR;
            end
            default: ifid_d = ifid_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_q.valid <= 1'b0;
            ifid_q.pc    <= '0;
            ifid_q.instr <= NOP_INSTR;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign ifid_o = ifid_q;

endmodule

// File: rtl/if_stage.sv
// RV32 instruction-fetch stage: PC register, ROM address and IF/ID handoff.
// Optional macro IF_FETCH_CNT_EN adds the fetch_cnt_o advance counter.
module if_stage #(
    parameter logic [31:0] RESET_PC = core_pkg::RESET_PC_DEFAULT,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            id_ready_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            id_valid_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [31:0]     id_instr_o
`ifdef IF_FETCH_CNT_EN
    ,
    output logic [31:0]     fetch_cnt_o
`endif
);

    import core_pkg::*;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            advance;
    ifid_op_e        ifid_op;
    if_id_t          ifid;

    // A redirect wins over stall; the IF/ID contents are treated as consumed.
    assign advance = !redirect_valid_i && (id_ready_i || !ifid.valid);

    always_comb begin
        pc_d    = pc_q;
        ifid_op = IFID_HOLD;
        if (redirect_valid_i) begin
            pc_d    = {redirect_pc_i[XLEN-1:2], 2'b00};
            ifid_op = IFID_FLUSH;
        end else if (advance) begin
            pc_d    = pc_q + XLEN'(PC_STEP);
            ifid_op = IFID_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= XLEN'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .op_i    (ifid_op),
        .pc_i    (pc_q),
        .instr_i (imem_rdata),
        .ifid_o  (ifid)
    );

    assign imem_addr  = pc_q;
    assign id_valid_o = ifid.valid;
    assign id_pc_o    = ifid.pc;
    assign id_instr_o = ifid.instr;

`ifdef IF_FETCH_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        if (advance) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
`endif

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the single-issue RV32 core. It holds the program counter and drives the combinational instruction ROM address. It captures the returned instruction into the IF/ID pipeline register and hands it to decode with a valid/ready handshake. It also accepts branch/jump redirects from execute, flushing the in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
XLEN, 32, address/instruction width; only 32 is supported.

Ports:
clk  in  1  core clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
imem_addr  out  XLEN  byte address to instruction ROM; equals pc_q, combinational.
imem_rdata  in  32  instruction from ROM; valid in the same cycle as imem_addr.
id_ready_i  in  1  decode can accept an instruction this cycle.
redirect_valid_i  in  1  execute requests PC change (taken branch/jump).
redirect_pc_i  in  XLEN  redirect target byte address.
id_valid_o  out  1  IF/ID register holds a valid instruction.
id_pc_o  out  XLEN  PC of the instruction in IF/ID.
id_instr_o  out  32  instruction in IF/ID; NOP when invalid.

Behaviour:
- Reset (rst=1 at the edge): pc_q<=RESET_PC, id_valid_o<=0, id_pc_o<=0, id_instr_o<=32'h0000_0013 (NOP). Reset mid-operation discards any pending redirect or held instruction.
- imem_addr = pc_q at all times. The ROM is combinational, so fetch completes within the cycle. Bits [1:0] of pc_q are always 0.
- Fetch accept: advance = !rst && !redirect_valid_i && (id_ready_i || !id_valid_o).
- Priority per edge: rst > redirect > advance > hold.
- Redirect: pc_q<=redirect_pc_i with bits [1:0] forced to 0, id_valid_o<=0, id_instr_o<=NOP, id_pc_o unchanged. A redirect overrides stall. It costs exactly one bubble: the first target instruction is valid in IF/ID two edges after the redirect is asserted.
- Advance: pc_q<=pc_q+4, id_valid_o<=1, id_pc_o<=pc_q, id_instr_o<=imem_rdata.
- Hold (id_valid_o=1, id_ready_i=0, no redirect): pc_q, id_valid_o, id_pc_o and id_instr_o are all unchanged, and no instruction is lost or duplicated.
- Latency: the instruction at address A is presented on id_instr_o one edge after pc_q==A is accepted. The first instruction after reset release is valid after one edge.
- Wrap-around: pc 32'hFFFF_FFFC + 4 -> 32'h0000_0000 (modulo 2^32, no flag).
- Simultaneous redirect and id_ready_i=1: the redirect wins and the current IF/ID contents are assumed consumed by decode this cycle. The refill is a bubble.
- No internal FSM beyond valid bit + PC. The states are EMPTY (id_valid_o=0) and FULL (id_valid_o=1):
  - EMPTY->FULL on advance.
  - FULL->EMPTY on redirect.
  - FULL->FULL on advance or hold.

Optional Feature:
Macro IF_FETCH_CNT_EN.
- Defined: adds output fetch_cnt_o [31:0]. It resets to 0, increments by 1 on every advance edge, wraps at 2^32, and does not count redirect or hold cycles.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package core_pkg:
  - XLEN.
  - RESET_PC default.
  - PC_STEP=4.
  - NOP_INSTR=32'h0000_0013.
  - Typedef if_id_t {valid, pc, instr}, reused by decode.
- One sub-module, if_id_reg, is natural: the IF/ID register with load/hold/flush controls. pc_q and the next-PC mux stay in if_stage.

Test Plan:
1. Reset with RESET_PC=0 and ROM[0..3]=002102B3, 003102B3, 004102B3, 005102B3, id_ready_i=1, then release -> edges 1..4 show id_pc_o 0,4,8,C with matching instructions; id_valid_o=1 from edge 1.
2. Backpressure: id_ready_i=0 for 3 cycles while holding pc 4 -> id_pc_o=4 and id_instr_o=003102B3 stable, imem_addr=8 stable. Release -> next id_pc_o=8, no skip or duplicate.
3. Redirect to 32'h0000_0010 while FULL, with and without id_ready_i=0 -> next edge id_valid_o=0 and id_instr_o=00000013; following edge id_pc_o=10.
4. Misaligned redirect 32'h0000_0016 -> pc_q=14, imem_addr=14.
5. Wrap: force pc 32'hFFFF_FFFC with advance -> id_pc_o=FFFF_FFFC, then imem_addr=0.
6. Reset asserted while FULL and redirect pending -> next edge pc_q=RESET_PC, id_valid_o=0. With IF_FETCH_CNT_EN, after 5 advances, 1 redirect and 2 holds -> fetch_cnt_o=5, and it is 0 after reset.
